// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg: shared word width, opcode constants and FSM state encoding for the risc_spm core
package risc_spm_pkg;

    localparam int WORD_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_RD   = 4'h5;
    localparam logic [3:0] OP_WR   = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FET1, S_DEC, S_EX1, S_RD1, S_WR1, S_BR1, S_HALT
    } state_t;

    // ALU opcodes occupy the contiguous range ADD..NOT
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/risc_spm_alu.sv
// risc_spm_alu: combinational 8-bit ALU; a is R[src], b is R[dest], carry/borrow discarded
module risc_spm_alu
    import risc_spm_pkg::*;
(
    input  logic [3:0] opcode,
    input  word_t      a,
    input  word_t      b,
    output word_t      result,
    output logic       zero
);

    assign result = (opcode == OP_ADD) ? a + b :
                    (opcode == OP_SUB) ? b - a :
                    (opcode == OP_AND) ? a & b :
                    (opcode == OP_NOT) ? ~a    : '0;
    assign zero   = (result == '0);

endmodule

// File: rtl/risc_spm_core.sv
// risc_spm_core: multi-cycle stored-program CPU core; RISC_SPM_INSTR_CNT_EN adds a saturating retired-instruction counter
module risc_spm_core
    import risc_spm_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       halted
`ifdef RISC_SPM_INSTR_CNT_EN
    ,
    output logic [15:0] instr_cnt
`endif
);

    state_t          state_q;
    word_t           pc_q;
    word_t           ir_q;
    word_t           addr_q;
    logic [3:0][7:0] r_q;
    logic            z_q;
    logic            halted_q;
    logic [3:0]      opcode;
    logic [1:0]      src;
    logic [1:0]      dest;
    logic            dec_two;
    word_t           alu_res;
    logic            alu_zero;

    assign opcode = ir_q[7:4];
    assign src    = ir_q[3:2];
    assign dest   = ir_q[1:0];

    // instructions that consume their address byte and move on to a second execute state
    assign dec_two = (opcode == OP_RD) || (opcode == OP_WR) || (opcode == OP_BR) ||
                     ((opcode == OP_BRZ) && z_q);

    risc_spm_alu u_alu (
        .opcode (opcode),
        .a      (r_q[src]),
        .b      (r_q[dest]),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign mem_addr  = (state_q inside {S_RD1, S_WR1, S_BR1}) ? addr_q : pc_q;
    assign mem_we    = (state_q == S_WR1);
    assign mem_wdata = mem_we ? r_q[src] : '0;
    assign halted    = halted_q;

    // control FSM together with the architectural registers it updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            addr_q   <= '0;
            r_q      <= '0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_FET1;
                S_FET1: begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_q + 8'd1;
                    state_q <= S_DEC;
                end
                S_DEC: begin
                    if (is_alu(opcode)) begin
                        state_q <= S_EX1;
                    end else if (opcode == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (dec_two) begin
                        addr_q  <= mem_rdata;
                        pc_q    <= pc_q + 8'd1;
                        state_q <= (opcode == OP_RD) ? S_RD1 :
                                   (opcode == OP_WR) ? S_WR1 : S_BR1;
                    end else begin
                        // untaken BRZ skips its address byte; NOP and illegal opcodes just refetch
                        if (opcode == OP_BRZ) pc_q <= pc_q + 8'd1;
                        state_q <= S_FET1;
                    end
                end
                S_EX1: begin
                    r_q[dest] <= alu_res;
                    z_q       <= alu_zero;
                    state_q   <= S_FET1;
                end
                S_RD1: begin
                    r_q[dest] <= mem_rdata;
                    state_q   <= S_FET1;
                end
                S_WR1:  state_q <= S_FET1;
                S_BR1: begin
                    pc_q    <= mem_rdata;
                    state_q <= S_FET1;
                end
                S_HALT: state_q <= S_HALT;
            endcase
        end
    end

`ifdef RISC_SPM_INSTR_CNT_EN
    logic [15:0] cnt_q;
    logic        fet_next;

    assign fet_next  = (state_q inside {S_EX1, S_RD1, S_WR1, S_BR1}) ||
                       ((state_q == S_DEC) && !is_alu(opcode) && (opcode != OP_HALT) && !dec_two);
    assign instr_cnt = cnt_q;

    // count each instruction as it completes back into fetch, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (fet_next && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_risc_spm_core.sv
// tb_risc_spm_core: scoreboard bench; stimulus queues expected writes and end-of-program state, a monitor compares them
module tb_risc_spm_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       halted;
`ifdef RISC_SPM_INSTR_CNT_EN
    logic [15:0] instr_cnt;
`endif

    logic [7:0] mem [256];

    typedef struct {
        int          id;
        logic [15:0] exp;
    } item_t;

    item_t       halt_q[$];
    logic [15:0] wr_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        halted_prev = 1'b0;
    string       nm [0:8] = '{"R0", "R1", "R2", "R3", "Z", "PC", "mem200", "cycles", "instr_cnt"};

    risc_spm_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .halted    (halted)
`ifdef RISC_SPM_INSTR_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else if (!halted) cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] actual(input int id);
        case (id)
            0: return {8'h00, dut.r_q[0]};
            1: return {8'h00, dut.r_q[1]};
            2: return {8'h00, dut.r_q[2]};
            3: return {8'h00, dut.r_q[3]};
            4: return {15'd0, dut.z_q};
            5: return {8'h00, mem_addr};
            6: return {8'h00, mem[200]};
            7: return cyc[15:0];
`ifdef RISC_SPM_INSTR_CNT_EN
            8: return instr_cnt;
`endif
            default: return 16'hDEAD;
        endcase
    endfunction

    // monitor: every write strobe and every rising halted consumes queued expectations
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (wr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                check("write", {mem_addr, mem_wdata}, wr_q.pop_front());
            end
        end
        if (halted && !halted_prev) begin
            while (halt_q.size() != 0) begin
                item_t it;
                it = halt_q.pop_front();
                check(nm[it.id], actual(it.id), it.exp);
            end
        end
        halted_prev = halted;
    end

    task automatic put(input int a, input logic [7:0] b);
        mem[a[7:0]] = b;
    endtask

    task automatic exp_h(input int id, input logic [15:0] v);
        halt_q.push_back('{id, v});
    endtask

    task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic begin_prog();
        rst_n = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input string name, input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_halt_timeout: got no halt after %0d cycles expected halted=1", name, max);
            halt_q.delete();
        end
        @(negedge clk);
        check({name, "_pending_writes"}, wr_q.size(), 16'd0);
        wr_q.delete();
    endtask

    initial begin
        // loop program: R1 counts 6 down to 0 while R3 accumulates R2
        begin_prog();
        put(0, 8'h00);
        put(1, 8'h52); put(2, 8'd130);
        put(3, 8'h53); put(4, 8'd131);
        put(5, 8'h51); put(6, 8'd128);
        put(7, 8'h50); put(8, 8'd129);
        put(9, 8'h21);
        put(10, 8'h80); put(11, 8'd134);
        put(12, 8'h1B);
        put(13, 8'h70); put(14, 8'd140);
        put(128, 8'd6); put(129, 8'd1); put(130, 8'd2); put(131, 8'd0);
        put(134, 8'd139); put(139, 8'hF0); put(140, 8'd9);
        @(negedge clk);
        check("rst_mem_addr", {8'h00, mem_addr}, 16'h0000);
        check("rst_mem_we", {15'd0, mem_we}, 16'h0000);
        check("rst_mem_wdata", {8'h00, mem_wdata}, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        exp_h(0, 16'd1); exp_h(1, 16'd0); exp_h(2, 16'd2); exp_h(3, 16'd10);
        exp_h(4, 16'd1); exp_h(5, 16'd140);
`ifdef RISC_SPM_INSTR_CNT_EN
        // NOP + 4 RD, five full passes of SUB/BRZ/ADD/BR, then the final SUB and taken BRZ
        exp_h(8, 16'(5 + 4 * 5 + 2));
`endif
        release_rst();
        run("loop", 500);

        // RD then WR: one write of A5 to address 200, 1+3+3+2 cycles to halt
        begin_prog();
        put(0, 8'h50); put(1, 8'd128);
        put(2, 8'h60); put(3, 8'd200);
        put(4, 8'hF0);
        put(128, 8'hA5);
        exp_w(8'd200, 8'hA5);
        exp_h(0, 16'h00A5); exp_h(6, 16'h00A5); exp_h(5, 16'd5); exp_h(7, 16'd9);
        release_rst();
        run("wr", 100);

        // ADD wraps FF+01 to zero and sets Z
        begin_prog();
        put(0, 8'h51); put(1, 8'd128);
        put(2, 8'h52); put(3, 8'd129);
        put(4, 8'h19); put(5, 8'hF0);
        put(128, 8'hFF); put(129, 8'h01);
        exp_h(1, 16'h0000); exp_h(2, 16'h0001); exp_h(4, 16'd1); exp_h(5, 16'd6);
        release_rst();
        run("add_wrap", 100);

        // same wrap, then NOT R2 into R0 clears Z
        begin_prog();
        put(0, 8'h51); put(1, 8'd128);
        put(2, 8'h52); put(3, 8'd129);
        put(4, 8'h19); put(5, 8'h48); put(6, 8'hF0);
        put(128, 8'hFF); put(129, 8'h01);
        exp_h(0, 16'h00FE); exp_h(1, 16'h0000); exp_h(2, 16'h0001); exp_h(4, 16'd0);
        release_rst();
        run("not", 100);

        // AND, ADD with src==dest, SUB with borrow
        begin_prog();
        put(0, 8'h50); put(1, 8'd128);
        put(2, 8'h51); put(3, 8'd129);
        put(4, 8'h31); put(5, 8'h10); put(6, 8'h22); put(7, 8'hF0);
        put(128, 8'h3C); put(129, 8'hA5);
        exp_h(0, 16'h0078); exp_h(1, 16'h0024); exp_h(2, 16'h0088); exp_h(4, 16'd0);
        release_rst();
        run("and_sub", 100);

        // illegal 9C would write R0 if decoded as an ALU op; it must cost 2 cycles and change nothing
        begin_prog();
        put(0, 8'h50); put(1, 8'd128);
        put(2, 8'h9C); put(3, 8'hF0);
        put(128, 8'h5A);
        exp_h(0, 16'h005A); exp_h(3, 16'h0000); exp_h(4, 16'd0); exp_h(5, 16'd4); exp_h(7, 16'd8);
        release_rst();
        run("illegal", 100);

        // reset dropped while the WR sits in decode: no write, restart from address 0
        begin_prog();
        put(0, 8'h50); put(1, 8'd128);
        put(2, 8'h60); put(3, 8'd200);
        put(4, 8'hF0);
        put(128, 8'hA5);
        release_rst();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midwr_mem_addr", {8'h00, mem_addr}, 16'h0000);
        check("midwr_mem_we", {15'd0, mem_we}, 16'h0000);
        check("midwr_mem_wdata", {8'h00, mem_wdata}, 16'h0000);
        check("midwr_halted", {15'd0, halted}, 16'h0000);
        repeat (3) @(negedge clk);
        check("midwr_no_write", {8'h00, mem[200]}, 16'h0000);
        exp_w(8'd200, 8'hA5);
        exp_h(0, 16'h00A5); exp_h(6, 16'h00A5); exp_h(5, 16'd5);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("restart_fetch_addr", {8'h00, mem_addr}, 16'h0000);
        run("restart", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
